// File: rtl/pipe_pkg.sv
// Shared defaults and sizing helpers for the elastic pipeline.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic slot: valid bit plus payload register with load, hold and valid-clear.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (load) begin
        valid <= src_valid;
        // Bubbles do not disturb the held payload.
        if (src_valid) data <= src_data;
      end
      if (clear) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic register pipeline with combinational backpressure, bubble collapse and per-stage flush.
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        flush,
  input  logic [DEPTH-1:0]            flush_mask,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [OCC_W-1:0] occ;

  // A stage can take new data if it is empty or everything downstream of it moves.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !v[i] || rdy[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             sv;
    logic [WIDTH-1:0] sd;

    if (i == 0) begin : g_head
      assign sv = in_valid;
      assign sd = in_data;
    end else begin : g_body
      assign sv = v[i-1];
      assign sd = d[i-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (rdy[i]),
      .clear    (flush && flush_mask[i]),
      .src_valid(sv),
      .src_data (sd),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(v[i]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ;

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe: slot-level reference model feeds expected outputs to a monitor.
module tb_elastic_pipe;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          flush;
  logic [D-1:0]  flush_mask;
  logic [2:0]    occupancy;

  elastic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .flush_mask(flush_mask),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  bit mon_en   = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: slot contents, index 0 nearest the input.
  bit           m_v[D];
  logic [W-1:0] m_d[D];
  bit           m_outv;
  logic [W-1:0] m_outd;
  bit           m_inrdy;
  int           m_occ;

  initial begin
    for (int j = 0; j < D; j++) begin
      m_v[j] = 0;
      m_d[j] = '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: items blocked at the output end stay put, everything behind the first gap moves up one slot.
  always @(negedge clk) begin : model
    int           stuck;
    bit           nv[D];
    logic [W-1:0] nd[D];
    m_outv = m_v[D-1];
    m_outd = m_d[D-1];
    m_occ  = 0;
    for (int j = 0; j < D; j++) m_occ += int'(m_v[j]);
    stuck = 0;
    if (!out_ready) begin
      while (stuck < D && m_v[D-1-stuck]) stuck++;
    end
    m_inrdy = (stuck < D);
    if (!rst) begin
      for (int j = 0; j < D; j++) begin
        m_v[j] = 0;
        m_d[j] = '0;
      end
    end else begin
      if (m_v[D-1] && out_ready) exp_q.push_back(m_d[D-1]);
      for (int j = 0; j < D; j++) begin
        if (j >= D - stuck) begin
          nv[j] = m_v[j];
          nd[j] = m_d[j];
        end else if (j == 0) begin
          nv[j] = in_valid;
          nd[j] = in_valid ? in_data : m_d[0];
        end else begin
          nv[j] = m_v[j-1];
          nd[j] = m_v[j-1] ? m_d[j-1] : m_d[j];
        end
      end
      for (int j = 0; j < D; j++) begin
        if (flush && flush_mask[j]) nv[j] = 0;
        m_v[j] = nv[j];
        m_d[j] = nd[j];
      end
    end
  end

  // Monitor: compares DUT outputs with the model snapshot and pops the scoreboard on each transfer.
  always begin : monitor
    logic [W-1:0] e;
    @(negedge clk);
    #1;
    if (mon_en) begin
      chk("out_valid", out_valid, m_outv);
      chk("in_ready", in_ready, m_inrdy);
      chk("occupancy", occupancy, m_occ);
      if (m_outv) chk("out_data_held", out_data, m_outd);
      if (rst && out_valid && out_ready) begin
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected no output (t=%0t)", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          n_checks--;
          chk("sb_data", out_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int first, input int count, input int cycles, output int sent);
    int nxt;
    bit acc;
    nxt  = first;
    sent = 0;
    for (int c = 0; c < cycles; c++) begin
      if (sent < count) begin
        in_valid = 1'b1;
        in_data  = W'(nxt);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        sent++;
        nxt++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    int sent;
    int n0;
    rst        = 1'b0;
    in_valid   = 1'b1;
    in_data    = 32'hAA;
    out_ready  = 1'b1;
    flush      = 1'b0;
    flush_mask = '0;

    // Reset held two cycles with input offered.
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    mon_en   = 1;
    step();

    // Latency: single push, visible exactly DEPTH cycles later.
    in_valid = 1'b1;
    in_data  = 32'h11;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("lat_valid_c%0d", k), out_valid, (k == D));
      if (k == D) chk("lat_data", out_data, 32'h11);
      step();
    end

    // Backpressure: only DEPTH items fit, head held.
    out_ready = 1'b0;
    push_seq(1, 6, 8, sent);
    chk("bp_accepted", sent, 4);
    chk("bp_occupancy", occupancy, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_data, 32'h1);
    n0 = n_out;
    out_ready = 1'b1;
    push_seq(5, 2, 4, sent);
    idle(8);
    chk("bp_drain_count", n_out - n0, 6);

    // Partial flush of the two input-side stages.
    out_ready = 1'b0;
    push_seq(1, 4, 8, sent);
    chk("pf_full", occupancy, 4);
    flush      = 1'b1;
    flush_mask = 4'b0011;
    step();
    flush      = 1'b0;
    flush_mask = '0;
    chk("pf_occupancy", occupancy, 2);
    n0 = n_out;
    out_ready = 1'b1;
    idle(6);
    chk("pf_emitted", n_out - n0, 2);

    // Input collides with a flush of stage 0.
    in_valid   = 1'b1;
    in_data    = 32'h55;
    flush      = 1'b1;
    flush_mask = 4'b0001;
    step();
    in_valid   = 1'b0;
    flush      = 1'b0;
    flush_mask = '0;
    chk("col_occupancy", occupancy, 0);
    n0 = n_out;
    idle(6);
    chk("col_emitted", n_out - n0, 0);

    // Reset while three items are in flight.
    out_ready = 1'b0;
    push_seq(32'h21, 3, 6, sent);
    chk("mr_occupancy", occupancy, 3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mr_occ_after", occupancy, 0);
    chk("mr_valid_after", out_valid, 0);
    n0 = n_out;
    out_ready = 1'b1;
    idle(8);
    chk("mr_emitted", n_out - n0, 0);

    // Randomized traffic with occasional flushes and resets.
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = $urandom;
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      flush_mask = D'($urandom);
      rst        = ($urandom_range(0, 299) != 0);
      step();
    end
    rst        = 1'b1;
    in_valid   = 1'b0;
    flush      = 1'b0;
    flush_mask = '0;
    out_ready  = 1'b1;
    idle(10);
    chk("final_occupancy", occupancy, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  last stage holds valid payload.
REQ-009 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  last-stage payload.
REQ-011 SHALL have port flush  input  1  qualify flush_mask this cycle.
REQ-012 SHALL have port flush_mask  input  DEPTH  bit i invalidates stage i (bit 0 = input side).
REQ-013 SHALL have port occupancy  output  clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 SHALL hold per stage i a valid bit v[i] and data register d[i]; stage 0 fed by in_*, stage DEPTH-1 drives out_*.
REQ-015 SHALL define ready[DEPTH] = out_ready and ready[i] = !v[i] || ready[i+1], combinational, no registered backpressure.
REQ-016 SHALL drive in_ready = ready[0]; input transfer occurs when in_valid && in_ready.
REQ-017 SHALL load stage i from stage i-1 (stage 0 from input) when ready[i]; v[i] takes the source valid, so bubbles collapse.
REQ-018 SHALL hold d[i] and v[i] unchanged when !ready[i].
REQ-019 SHALL give latency of exactly DEPTH cycles: input accepted in cycle t appears on out_* in cycle t+DEPTH when never stalled.
REQ-020 SHALL sustain throughput of one transfer per cycle with out_ready held high.
REQ-021 SHALL keep out_data stable while out_valid && !out_ready.
REQ-022 SHALL preserve order; no duplication or loss except by flush or reset.
REQ-023 SHALL, when flush=1, force next v[i]=0 for every i with flush_mask[i]=1, overriding any load into that stage in the same cycle.
REQ-024 SHALL compute in_ready and output transfer in a flush cycle from current state; an input accepted while flush_mask[0]=1 is dropped.
REQ-025 SHALL ignore flush_mask when flush=0; flush clears valid bits only, not data.
REQ-026 SHALL drive occupancy = popcount(v), registered-state derived, range 0..DEPTH.
REQ-027 SHALL keep in_ready=1 with empty pipe regardless of out_ready.

Reset
REQ-028 SHALL, on clk edge with rst=0, clear all v[i] and d[i] to 0, overriding handshake and flush.
REQ-029 SHALL present out_valid=0, out_data=0, occupancy=0, in_ready=1 in the cycle after reset.
REQ-030 SHALL discard all in-flight payloads on reset mid-operation; none emitted afterwards.

Structure
REQ-031 SHALL place default WIDTH/DEPTH constants and the occupancy-width function in shared package pipe_pkg.
REQ-032 SHALL instantiate DEPTH copies of sub-module pipe_stage (one valid+data slot with load, hold, clear) via generate.

Verification (WIDTH=32, DEPTH=4)
REQ-033 SHALL check reset: rst=0 two cycles with in_valid=1 -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
REQ-034 SHALL check latency: push 0x11 at cycle 0, out_ready=1 -> out_valid=1, out_data=0x11 at cycle 4 only.
REQ-035 SHALL check backpressure: out_ready=0, push 0x1..0x6 -> 0x1..0x4 accepted, occupancy=4, in_ready=0, out_data=0x1 held; then out_ready=1 -> 0x1..0x6 out in order.
REQ-036 SHALL check partial flush: full with 0x1..0x4 (0x1 at stage 3), flush=1, flush_mask=4'b0011 -> occupancy=2, only 0x1,0x2 emitted.
REQ-037 SHALL check flush/input collision: push 0x55 with flush=1, flush_mask[0]=1 -> 0x55 never emitted, occupancy unchanged by it.
REQ-038 SHALL check mid-run reset: occupancy=3, rst=0 one cycle -> next cycle occupancy=0, out_valid=0, no later output.
